// File: rtl/c4_pkg.sv
// Shared Connect-4 types: cell encoding, board size, scanner states and
// the line-direction delta table.
package c4_pkg;

  localparam int C4_COLS = 7;
  localparam int C4_ROWS = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    REPORT
  } scan_state_t;

  typedef struct packed {
    logic signed [3:0] dc;
    logic signed [3:0] dr;
  } delta_t;

  // 0 horizontal, 1 vertical, 2 rising diagonal, 3 falling diagonal
  function automatic delta_t dir_delta(input logic [1:0] dir);
    delta_t d;
    d.dc = 4'sd1;
    d.dr = 4'sd0;
    unique case (dir)
      2'd0: begin d.dc = 4'sd1; d.dr = 4'sd0;  end
      2'd1: begin d.dc = 4'sd0; d.dr = 4'sd1;  end
      2'd2: begin d.dc = 4'sd1; d.dr = 4'sd1;  end
      2'd3: begin d.dc = 4'sd1; d.dr = -4'sd1; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/c4_coord_step.sv
// Combinational neighbour coordinate: base + sign*step*delta(dir), with a
// board bounds check. 4-bit signed math; any overflow lands negative (oob).
module c4_coord_step
  import c4_pkg::*;
#(
  parameter int COLS = C4_COLS,
  parameter int ROWS = C4_ROWS
) (
  input  logic [2:0] base_col,
  input  logic [2:0] base_row,
  input  logic [1:0] dir,
  input  logic       neg,
  input  logic [1:0] step,
  output logic [2:0] tgt_col,
  output logic [2:0] tgt_row,
  output logic       oob
);

  delta_t            d;
  logic signed [3:0] st;
  logic signed [3:0] off_c;
  logic signed [3:0] off_r;
  logic signed [3:0] tc;
  logic signed [3:0] tr;

  always_comb begin
    d     = dir_delta(dir);
    st    = $signed({2'b00, step});
    off_c = st * d.dc;
    off_r = st * d.dr;
    if (neg) begin
      off_c = -off_c;
      off_r = -off_r;
    end
    tc      = $signed({1'b0, base_col}) + off_c;
    tr      = $signed({1'b0, base_row}) + off_r;
    tgt_col = tc[2:0];
    tgt_row = tr[2:0];
    oob     = tc[3] || tr[3] ||
              (int'(tc[2:0]) >= COLS) || (int'(tr[2:0]) >= ROWS);
  end

endmodule

// File: rtl/win_scanner.sv
// Connect-4 win scanner: walks four line directions through the last move,
// one RAM read at a time. Optional draw detection under WIN_SCANNER_DRAW_EN.
module win_scanner
  import c4_pkg::*;
#(
  parameter int COLS = C4_COLS,
  parameter int ROWS = C4_ROWS,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    col,
  input  logic [2:0]    row,
  input  logic          player,
  output logic [AW-1:0] raddr,
  input  logic [1:0]    rdata,
  output logic          busy,
  output logic          done,
  output logic          win1,
  output logic          win2,
  output logic          draw
);

  scan_state_t state, state_nx;
  logic [2:0]  bcol, brow;
  logic        ply;
  logic [2:0]  run, run_nx;
  logic [1:0]  dir;
  logic        neg;
  logic [1:0]  step;
  logic [2:0]  tcol, trow;
  logic        oob;
  logic        accept, match;
  logic        eor, eor_win, eor_last;
  cell_t       mover;

  c4_coord_step #(.COLS(COLS), .ROWS(ROWS)) u_step (
    .base_col (bcol),
    .base_row (brow),
    .dir      (dir),
    .neg      (neg),
    .step     (step),
    .tgt_col  (tcol),
    .tgt_row  (trow),
    .oob      (oob)
  );

  assign accept = (state == IDLE) && start && !win1 && !win2;
  assign mover  = ply ? P2 : P1;
  assign match  = (rdata == mover);

  always_comb begin
    run_nx = run;
    if (state == CHECK && match && run != 3'd7) run_nx = run + 3'd1;
  end

  // End of ray: off the board, a different cell, or three cells walked
  always_comb begin
    eor = 1'b0;
    if (state == ISSUE)      eor = oob;
    else if (state == CHECK) eor = !match || (step == 2'd3);
  end

  assign eor_win  = eor && (run_nx >= 3'd4);
  assign eor_last = eor && !eor_win && neg && (dir == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   state_nx = oob ? ISSUE : WAIT;
      WAIT:    state_nx = CHECK;
      CHECK:   state_nx = ISSUE;
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (eor_win || eor_last) state_nx = REPORT;
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcol  <= '0;
      brow  <= '0;
      ply   <= 1'b0;
      run   <= '0;
      dir   <= '0;
      neg   <= 1'b0;
      step  <= '0;
      raddr <= '0;
      win1  <= 1'b0;
      win2  <= 1'b0;
    end else begin
      if (accept) begin
        bcol <= col;
        brow <= row;
        ply  <= player;
        run  <= 3'd1;
        dir  <= 2'd0;
        neg  <= 1'b0;
        step <= 2'd1;
      end
      // Registered address stays put through WAIT until the next ISSUE
      if (state == ISSUE && !oob) raddr <= AW'({trow, tcol});
      if (state == CHECK) begin
        run <= run_nx;
        if (match && step != 2'd3) step <= step + 2'd1;
      end
      if (eor) begin
        if (eor_win) begin
          if (ply) win2 <= 1'b1;
          else     win1 <= 1'b1;
        end else if (!neg) begin
          neg  <= 1'b1;
          step <= 2'd1;
        end else begin
          dir  <= dir + 2'd1;
          neg  <= 1'b0;
          step <= 2'd1;
          run  <= 3'd1;
        end
      end
    end
  end

`ifdef WIN_SCANNER_DRAW_EN
  logic [5:0] moves;

  always_ff @(posedge clk) begin
    if (rst) begin
      moves <= '0;
      draw  <= 1'b0;
    end else begin
      if (accept && moves != 6'h3f) moves <= moves + 6'd1;
      if (eor_last && int'(moves) == COLS * ROWS) draw <= 1'b1;
    end
  end
`else
  assign draw = 1'b0;
`endif

endmodule

// File: tb/tb_win_scanner.sv
// Directed test of win_scanner against a behavioural board RAM.
module tb_win_scanner;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    col = '0;
  logic [2:0]    row = '0;
  logic          player = 1'b0;
  logic [AW-1:0] raddr;
  logic [1:0]    rdata = '0;
  logic          busy, done, win1, win2, draw;

  logic [1:0] mem [64];
  int checks = 0;
  int failures = 0;
  int cyc, nd, bad7;

  win_scanner #(.COLS(7), .ROWS(6), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .col    (col),
    .row    (row),
    .player (player),
    .raddr  (raddr),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done),
    .win1   (win1),
    .win2   (win2),
    .draw   (draw)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[raddr];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 2'b00;
  endtask

  task automatic put(input int c, input int r, input logic [1:0] v);
    mem[r * 8 + c] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse start, then count busy cycles and done pulses until idle.
  // A second start is pulsed at busy cycle ms (ms < 0: none).
  task automatic scan(input int c, input int r, input logic p, input int ms);
    cyc = 0; nd = 0; bad7 = 0;
    @(negedge clk);
    start = 1'b1; col = 3'(c); row = 3'(r); player = p;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      cyc++;
      if (done) nd++;
      if (raddr[2:0] == 3'd7) bad7 = 1;
      start = (k == ms);
      @(negedge clk);
    end
    start = 1'b0;
    chk("scan_timeout", int'(busy), 0);
  endtask

  initial begin
    clear_mem();
    do_reset();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_win1", int'(win1), 0);
    chk("rst_win2", int'(win2), 0);
    chk("rst_draw", int'(draw), 0);
    chk("rst_raddr", int'(raddr), 0);

    // Horizontal: + side misses immediately, - side reads three P1 cells
    put(0, 0, 2'b01); put(1, 0, 2'b01); put(2, 0, 2'b01); put(3, 0, 2'b01);
    scan(3, 0, 1'b0, -1);
    chk("horiz_cycles", cyc, 13);
    chk("horiz_done", nd, 1);
    chk("horiz_win1", int'(win1), 1);
    chk("horiz_win2", int'(win2), 0);
    scan(4, 0, 1'b0, -1);
    chk("start_after_win_busy", cyc, 0);
    chk("start_after_win_done", nd, 0);

    // Vertical P2
    do_reset();
    chk("rst2_win1", int'(win1), 0);
    clear_mem();
    put(5, 0, 2'b10); put(5, 1, 2'b10); put(5, 2, 2'b10); put(5, 3, 2'b10);
    scan(5, 3, 1'b1, -1);
    chk("vert_cycles", cyc, 19);
    chk("vert_done", nd, 1);
    chk("vert_win2", int'(win2), 1);
    chk("vert_win1", int'(win1), 0);

    // Rising diagonal through the middle, both signs contribute
    do_reset();
    clear_mem();
    put(0, 0, 2'b01); put(1, 1, 2'b01); put(2, 2, 2'b01); put(3, 3, 2'b01);
    scan(2, 2, 1'b0, -1);
    chk("diag_done", nd, 1);
    chk("diag_win1", int'(win1), 1);
    chk("diag_win2", int'(win2), 0);

    // Right edge: (0,1) would only be reached by wrapping through column 7
    do_reset();
    clear_mem();
    put(4, 0, 2'b01); put(5, 0, 2'b01); put(6, 0, 2'b01); put(0, 1, 2'b01);
    scan(6, 0, 1'b0, -1);
    chk("nowrap_cycles", cyc, 21);
    chk("nowrap_done", nd, 1);
    chk("nowrap_win1", int'(win1), 0);
    chk("nowrap_col7", bad7, 0);

    // Start during busy is ignored
    scan(6, 0, 1'b0, 3);
    chk("busy_start_done", nd, 1);
    chk("busy_start_cycles", cyc, 21);

    // Reset mid-scan
    @(negedge clk);
    start = 1'b1; col = 3'd6; row = 3'd0; player = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("midscan_busy_before", int'(busy), 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midscan_busy", int'(busy), 0);
    chk("midscan_done", int'(done), 0);
    chk("midscan_win1", int'(win1), 0);
    chk("midscan_win2", int'(win2), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midscan_idle", int'(busy), 0);

`ifdef WIN_SCANNER_DRAW_EN
    do_reset();
    clear_mem();
    for (int n = 1; n <= 42; n++) begin
      scan(0, 0, 1'b0, -1);
      if (n == 41) chk("draw_at_41", int'(draw), 0);
    end
    chk("draw_at_42", int'(draw), 1);
    chk("draw_no_win", int'(win1), 0);
`else
    chk("draw_tied_low", int'(draw), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/win_scanner.md
# win_scanner

Reads the Connect-4 board memory that Control writes. It checks whether the coin just dropped completes a line of four and reports the result as sticky win flags. Control pulses `start` after each accepted `wen` write. The scanner then walks the four line directions through that cell, reading the board RAM one cell at a time, and returns a one-cycle `done` with the outcome.

## Interface
- `COLS`, default 7: board columns.
- `ROWS`, default 6: board rows.
- `AW`, default 6: board RAM address width.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse: the last move was written.
- `col`  in  3  column of the last move (0..COLS-1).
- `row`  in  3  row of the last move (0 = bottom).
- `player`  in  1  mover: 0 = player 1, 1 = player 2.
- `raddr`  out  AW  board RAM read address, row*8+col.
- `rdata`  in  2  cell contents: 00 empty, 01 player 1, 10 player 2; valid one cycle after `raddr`.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse at scan end.
- `win1`  out  1  sticky: player 1 has four in a row.
- `win2`  out  1  sticky: player 2 has four in a row.
- `draw`  out  1  board full with no win (only with macro; tied 0 otherwise).

## Operation
- **Reset values:** all outputs 0, `raddr` = 0; FSM goes to IDLE; move counter = 0.
- **IDLE:** on `start`, latch `col`, `row` and `player`, set run length = 1, set direction = 0, set sign = +, set step = 1, and go to ISSUE.
  - `start` while busy is ignored.
  - `start` while `win1` or `win2` is set is ignored.
- **Directions:** 0 = (+1,0) horizontal, 1 = (0,+1) vertical, 2 = (+1,+1), 3 = (+1,-1). Sign − negates the step.
- **ISSUE:** compute the target as base + sign·step·dir using 4-bit signed arithmetic.
  - Out of bounds (col<0, col≥COLS, row<0, row≥ROWS): go directly to the END-OF-RAY decision without a read.
  - Otherwise drive `raddr` and go to WAIT.
- **WAIT:** one cycle for RAM latency; then go to CHECK.
- **CHECK:**
  - `rdata` equals the mover code: increment run length (saturating at 7); if step < 3, increment step and go to ISSUE; else end ray.
  - Mismatch: end ray.
- **END-OF-RAY:**
  - Run ≥ 4: go to REPORT with win.
  - Sign +: switch to −, step = 1, go to ISSUE.
  - Sign −: direction+1, sign +, step = 1, run = 1. If direction was 3, go to REPORT with no win.
- **REPORT:** one cycle.
  - `done` = 1; `busy` deasserts the next cycle.
  - On win, set `win1` if player = 0, else `win2`.
  - Return to IDLE.
- **Flags:** `win1`/`win2` stay set until `rst`. Both are never set together.
- **Column 7:** address column 7 is never read; the bounds check prevents row wrap.
- **Reset mid-scan:** abort, return to IDLE, no `done`, flags cleared.

## Timing
- `busy` = 1 from the cycle after `start` through the REPORT cycle.
- Each in-bounds read costs 3 cycles: ISSUE, WAIT, CHECK. Each out-of-bounds step costs 1 cycle.
- Early exit as soon as any direction reaches a run ≥ 4.
- Worst case: 4 dirs × 2 signs × 3 steps × 3 cycles + REPORT = 73 cycles. This is well under one human `E` press.
- `raddr` is held stable during WAIT.

## Configuration
- **`WIN_SCANNER_DRAW_EN`:**
  - **Defined:** a 6-bit move counter increments on each accepted `start`. If a scan reports no win and the counter = COLS·ROWS (42), `draw` is set sticky in the REPORT cycle and stays set until `rst`.
  - **Undefined:** no counter; `draw` is tied 0.

## Structure
- **Shared package `c4_pkg`:**
  - `cell_t` enum (EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10).
  - Constants `C4_COLS`, `C4_ROWS`.
  - `scan_state_t` enum (IDLE, ISSUE, WAIT, CHECK, REPORT).
  - Direction delta lookup function.
- **Sub-module `c4_coord_step`:** combinational target computation plus bounds check from base, direction, sign and step. Instantiate it once.

## Test plan
- **Horizontal win:** P1 at (0,0),(1,0),(2,0) preloaded; start col=3,row=0,player=0 → `done` pulse, `win1`=1, `win2`=0.
- **Vertical win:** P2 stacked at col 5 rows 0-2; start col=5,row=3,player=1 → `win2`=1.
- **Diagonal win through middle:** P1 at (0,0),(1,1),(3,3); start (2,2) → `win1`=1. This exercises both signs.
- **No wrap across rows:** P1 at (4,0),(5,0),(6,0) and (0,1); start (6,0) → `done`, no win. Check `raddr` never has low 3 bits = 7.
- **Ignored starts:** start during `busy` → ignored, exactly one `done`. After `win1` is set, a further start → no `busy`. `rst` mid-scan → `busy`=0 next cycle, flags 0.
- **Draw (macro defined):** 42 accepted non-winning starts → `draw`=1 on the 42nd `done`. Without the macro, `draw` stays 0.
